// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADD_W  = 10;

   // Port identifiers, also used as the round-robin "last" marker
   localparam logic PORT_C = 1'b0;
   localparam logic PORT_E = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_C = 2'd1,
      OWN_E = 2'd2
   } arb_state_t;

   // One master's access request as seen by the RAM mux
   typedef struct packed {
      logic                   we;
      logic                   lock;
      logic [DMEM_ADD_W-1:0]  addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } mem_req_t;

   // Ownership state that a locked grant to the given port moves into
   function automatic arb_state_t own_state(input logic port);
      return (port == PORT_E) ? OWN_E : OWN_C;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie the port that did not win last time is chosen.
module rr_pick (
   input  logic [1:0] req_i,    // bit0 = port C, bit1 = port E
   input  logic       last_i,   // port granted most recently
   output logic       win_o,    // selected port
   output logic       valid_o   // at least one request present
);

   assign valid_o = |req_i;
   assign win_o   = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter between the core data port (C) and the loader/debug port (E).
// Round-robin with optional locked bursts capped at MAX_BURST contended grants,
// single-cycle combinational grant and a one-deep read-return pipeline.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int RAM_DATA  = DMEM_DATA_W,
   parameter int RAM_ADD   = DMEM_ADD_W,
   parameter int MAX_BURST = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                C_REQ,
   input  logic                C_WE,
   input  logic                C_LOCK,
   input  logic [RAM_ADD-1:0]  C_ADDR,
   input  logic [RAM_DATA-1:0] C_WDATA,
   output logic                C_GNT,
   output logic                C_RVALID,
   output logic [RAM_DATA-1:0] C_RDATA,
   input  logic                E_REQ,
   input  logic                E_WE,
   input  logic                E_LOCK,
   input  logic [RAM_ADD-1:0]  E_ADDR,
   input  logic [RAM_DATA-1:0] E_WDATA,
   output logic                E_GNT,
   output logic                E_RVALID,
   output logic [RAM_DATA-1:0] E_RDATA,
   output logic                RAM_WR,
   output logic                RAM_OE,
   output logic [RAM_ADD-1:0]  RAM_ADDRESS,
   output logic [RAM_DATA-1:0] RAM_DATA_IN,
   input  logic [RAM_DATA-1:0] RAM_DATA_OUT
);

   // Counter only needs to reach MAX_BURST-1: the cap forces a hand-over at that value
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_t          state_q, state_d;
   logic                rr_last_q, rr_last_d;
   logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic                rd_pend_q, rd_pend_d;
   logic                rd_id_q;
   logic [RAM_ADD-1:0]  addr_q;
   logic [RAM_DATA-1:0] wdata_q;

   logic                rr_win, rr_valid;
   logic                win, win_vld;
   logic                cap_hit;
   logic                other_req;
   logic                same_owner;
   mem_req_t            win_req;

   rr_pick u_rr_pick (
      .req_i   ({E_REQ, C_REQ}),
      .last_i  (rr_last_q),
      .win_o   (rr_win),
      .valid_o (rr_valid)
   );

   assign cap_hit = (burst_cnt_q == CNT_W'(MAX_BURST - 1));

   // Winner selection: a locked owner keeps the RAM unless the fairness cap hands it over
   always_comb begin
      win     = rr_win;
      win_vld = rr_valid;
      unique case (state_q)
         OWN_C: if (C_REQ) begin
            win_vld = 1'b1;
            win     = (E_REQ && cap_hit) ? PORT_E : PORT_C;
         end
         OWN_E: if (E_REQ) begin
            win_vld = 1'b1;
            win     = (C_REQ && cap_hit) ? PORT_C : PORT_E;
         end
         default: ;
      endcase
      if (RST) begin
         win_vld = 1'b0;
      end
   end

   // Request of the selected port
   always_comb begin
      if (win == PORT_E) begin
         win_req.we    = E_WE;
         win_req.lock  = E_LOCK;
         win_req.addr  = E_ADDR;
         win_req.wdata = E_WDATA;
      end else begin
         win_req.we    = C_WE;
         win_req.lock  = C_LOCK;
         win_req.addr  = C_ADDR;
         win_req.wdata = C_WDATA;
      end
   end

   assign other_req  = (win == PORT_C) ? E_REQ : C_REQ;
   assign same_owner = (state_q == own_state(win));

   // Next-state for ownership, round-robin pointer, burst counter and read-pending flag
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      burst_cnt_d = '0;
      rd_pend_d   = win_vld & ~win_req.we;
      if (win_vld) begin
         rr_last_d = win;
         state_d   = win_req.lock ? own_state(win) : IDLE;
         if (same_owner && other_req && win_req.lock) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
         end
      end
   end

   // Control registers, cleared by synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         rr_last_q   <= PORT_E;
         burst_cnt_q <= '0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   // Data-side registers: last winner's address/data and the owner of the pending read
   always_ff @(posedge CLK) begin
      if (win_vld) begin
         addr_q  <= win_req.addr;
         wdata_q <= win_req.wdata;
         rd_id_q <= win;
      end
   end

   // RAM side: address/data hold the last winner's values while idle so the bus never toggles
   assign RAM_WR      = win_vld &  win_req.we;
   assign RAM_OE      = win_vld & ~win_req.we;
   assign RAM_ADDRESS = win_vld ? win_req.addr  : addr_q;
   assign RAM_DATA_IN = win_vld ? win_req.wdata : wdata_q;

   assign C_GNT = win_vld & (win == PORT_C);
   assign E_GNT = win_vld & (win == PORT_E);

   // Read return; reset suppresses a read that was in flight
   assign C_RVALID = ~RST & rd_pend_q & (rd_id_q == PORT_C);
   assign E_RVALID = ~RST & rd_pend_q & (rd_id_q == PORT_E);
   assign C_RDATA  = C_RVALID ? RAM_DATA_OUT : '0;
   assign E_RDATA  = E_RVALID ? RAM_DATA_OUT : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants and read returns,
// a negedge monitor pops and compares whenever the DUT presents a grant or RVALID.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        RST;
   logic        C_REQ, C_WE, C_LOCK;
   logic [9:0]  C_ADDR;
   logic [31:0] C_WDATA;
   logic        C_GNT, C_RVALID;
   logic [31:0] C_RDATA;
   logic        E_REQ, E_WE, E_LOCK;
   logic [9:0]  E_ADDR;
   logic [31:0] E_WDATA;
   logic        E_GNT, E_RVALID;
   logic [31:0] E_RDATA;
   logic        RAM_WR, RAM_OE;
   logic [9:0]  RAM_ADDRESS;
   logic [31:0] RAM_DATA_IN;
   logic [31:0] RAM_DATA_OUT;

   typedef struct {
      logic        port;
      logic [9:0]  addr;
      logic        we;
      logic [31:0] wdata;
   } gexp_t;

   typedef struct {
      logic        port;
      logic [31:0] data;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   dmem_arbiter #(.RAM_DATA(32), .RAM_ADD(10), .MAX_BURST(8)) dut (
      .CLK          (clk),
      .RST          (RST),
      .C_REQ        (C_REQ),
      .C_WE         (C_WE),
      .C_LOCK       (C_LOCK),
      .C_ADDR       (C_ADDR),
      .C_WDATA      (C_WDATA),
      .C_GNT        (C_GNT),
      .C_RVALID     (C_RVALID),
      .C_RDATA      (C_RDATA),
      .E_REQ        (E_REQ),
      .E_WE         (E_WE),
      .E_LOCK       (E_LOCK),
      .E_ADDR       (E_ADDR),
      .E_WDATA      (E_WDATA),
      .E_GNT        (E_GNT),
      .E_RVALID     (E_RVALID),
      .E_RDATA      (E_RDATA),
      .RAM_WR       (RAM_WR),
      .RAM_OE       (RAM_OE),
      .RAM_ADDRESS  (RAM_ADDRESS),
      .RAM_DATA_IN  (RAM_DATA_IN),
      .RAM_DATA_OUT (RAM_DATA_OUT)
   );

   // RAM model: pattern-filled, one-cycle read latency
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
   end

   always @(posedge clk) begin
      if (RAM_WR) mem[RAM_ADDRESS] <= RAM_DATA_IN;
      if (RAM_OE) RAM_DATA_OUT <= mem[RAM_ADDRESS];
   end

   function automatic logic [31:0] pat(input logic [9:0] a);
      return 32'hC0DE_0000 + {22'd0, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic push_g(input logic p, input logic [9:0] a, input logic we, input logic [31:0] wd);
      gexp_t g;
      g.port = p; g.addr = a; g.we = we; g.wdata = wd;
      gq.push_back(g);
   endtask

   task automatic push_r(input logic p, input logic [31:0] d);
      rexp_t r;
      r.port = p; r.data = d;
      rq.push_back(r);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented grant and read return against the scoreboard
   always @(negedge clk) begin
      if (C_GNT || E_GNT) begin
         chk("grant_expected", 64'(gq.size() > 0), 64'd1);
         chk("single_grant", 64'(C_GNT & E_GNT), 64'd0);
         if (gq.size() > 0) begin
            gexp_t g;
            g = gq.pop_front();
            chk("grant_port", 64'(E_GNT), 64'(g.port));
            chk("ram_address", 64'(RAM_ADDRESS), 64'(g.addr));
            chk("ram_wr_oe", 64'({RAM_WR, RAM_OE}), 64'({g.we, ~g.we}));
            if (g.we) chk("ram_data_in", 64'(RAM_DATA_IN), 64'(g.wdata));
         end
      end
      if (C_RVALID || E_RVALID) begin
         chk("rvalid_expected", 64'(rq.size() > 0), 64'd1);
         if (rq.size() > 0) begin
            rexp_t r;
            r = rq.pop_front();
            chk("rvalid_port", 64'({E_RVALID, C_RVALID}), 64'(r.port ? 2'b10 : 2'b01));
            chk("rdata", 64'(E_RVALID ? E_RDATA : C_RDATA), 64'(r.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      C_REQ = 1'b1; C_WE = 1'b0; C_LOCK = 1'b0; C_ADDR = 10'h010; C_WDATA = 32'h0;
      E_REQ = 1'b1; E_WE = 1'b0; E_LOCK = 1'b0; E_ADDR = 10'h020; E_WDATA = 32'h0;

      // Reset held 3 cycles with both ports requesting: nothing may move
      repeat (3) begin
         @(negedge clk);
         chk("reset_quiet", 64'({C_GNT, E_GNT, C_RVALID, E_RVALID, RAM_WR, RAM_OE}), 64'd0);
         chk("reset_rdata", 64'({C_RDATA, E_RDATA}), 64'd0);
      end
      @(posedge clk);
      #1;
      RST = 1'b0;

      // Contended reads without lock: C first after reset, then strict alternation
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) begin
            push_g(1'b0, 10'h010, 1'b0, 32'h0);
            push_r(1'b0, pat(10'h010));
         end else begin
            push_g(1'b1, 10'h020, 1'b0, 32'h0);
            push_r(1'b1, pat(10'h020));
         end
         tick();
      end

      // Locked C write burst against E reads: 8 C, 1 E, then C again
      C_LOCK = 1'b1; C_WE = 1'b1; C_ADDR = 10'h100; C_WDATA = 32'h1111_0000;
      for (int i = 0; i < 10; i++) begin
         if (i == 8) begin
            push_g(1'b1, 10'h020, 1'b0, 32'h0);
            push_r(1'b1, pat(10'h020));
         end else begin
            push_g(1'b0, 10'h100, 1'b1, 32'h1111_0000);
         end
         tick();
      end

      // E writes 0xDEADBEEF to 0x3F1, C reads it back the next cycle
      C_REQ = 1'b0; C_LOCK = 1'b0; C_WE = 1'b0;
      E_WE = 1'b1; E_ADDR = 10'h3F1; E_WDATA = 32'hDEAD_BEEF;
      push_g(1'b1, 10'h3F1, 1'b1, 32'hDEAD_BEEF);
      tick();
      E_REQ = 1'b0; E_WE = 1'b0;
      C_REQ = 1'b1; C_ADDR = 10'h3F1;
      push_g(1'b0, 10'h3F1, 1'b0, 32'h0);
      push_r(1'b0, 32'hDEAD_BEEF);
      tick();
      C_REQ = 1'b0;
      tick();

      // Reset right after a granted read: its return must never appear
      C_REQ = 1'b1; C_ADDR = 10'h005;
      push_g(1'b0, 10'h005, 1'b0, 32'h0);
      tick();
      RST = 1'b1; C_REQ = 1'b0;
      @(negedge clk);
      chk("reset_midread_rvalid", 64'({C_RVALID, E_RVALID}), 64'd0);
      tick();
      tick();
      RST = 1'b0;
      repeat (3) tick();

      // Single requester E sweeping across the top of the address space and wrapping
      E_REQ = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [9:0] a;
         a = 10'(1020 + i);
         E_ADDR = a;
         push_g(1'b1, a, 1'b0, 32'h0);
         push_r(1'b1, pat(a));
         tick();
      end
      E_REQ = 1'b0;
      @(negedge clk);
      chk("idle_hold_address", 64'(RAM_ADDRESS), 64'h003);
      chk("idle_no_access", 64'({RAM_WR, RAM_OE, C_GNT, E_GNT}), 64'd0);
      repeat (3) tick();

      chk("grant_queue_drained", 64'(gq.size()), 64'd0);
      chk("read_queue_drained", 64'(rq.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
